// File: rtl/jr_resolve_unit.sv
// jr_resolve_unit: execute-stage checker for JR return-address predictions.
// Each JR prediction issued at fetch is queued in order. When the JR resolves in
// execute, the queue head is compared against the real target. A mispredict raises
// a one-cycle FLUSH_OUT together with the correct fetch address.
//
// Ports:
//   CLK, RESET          clock (rising edge), asynchronous active-low reset
//   Pred_*_IN           enqueue request from fetch: taken flag, predicted target, JR PC
//   Resolve_*_IN        resolving JR in execute: its PC and actual target
//   FLUSH_OUT           one-cycle flush on mispredict
//   Redirect_Addr_OUT   correct fetch address, meaningful while FLUSH_OUT=1
//   Full_OUT            queue holds DEPTH entries; fetch must stall JRs
//   Hit/Miss_Count_OUT  saturating prediction statistics
//   Error_OUT           sticky protocol error
module jr_resolve_unit #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             Pred_Valid_IN,
  input  logic             Pred_Taken_IN,
  input  logic [31:0]      Pred_Addr_IN,
  input  logic [31:0]      Pred_PC_IN,
  input  logic             Resolve_Valid_IN,
  input  logic [31:0]      Resolve_PC_IN,
  input  logic [31:0]      Resolve_Target_IN,
  output logic             FLUSH_OUT,
  output logic [31:0]      Redirect_Addr_OUT,
  output logic             Full_OUT,
  output logic [CNT_W-1:0] Hit_Count_OUT,
  output logic [CNT_W-1:0] Miss_Count_OUT,
  output logic             Error_OUT
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  typedef enum logic [0:0] {StRun, StFlush} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   count_q, count_d;
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [31:0]       redirect_q, redirect_d;
  logic [CNT_W-1:0]  hit_q, hit_d;
  logic [CNT_W-1:0]  miss_q, miss_d;
  logic              err_q, err_d;

  logic [31:0]       pc_mem   [DEPTH];
  logic [31:0]       addr_mem [DEPTH];
  logic              taken_mem[DEPTH];

  logic              empty, full;
  logic [31:0]       head_pc, head_addr;
  logic              head_taken;
  logic              do_pop, do_push, mispredict, mem_we;

  assign empty      = (count_q == '0);
  assign full       = (count_q == CntW'(DEPTH));
  assign head_pc    = pc_mem[rd_ptr_q];
  assign head_addr  = addr_mem[rd_ptr_q];
  assign head_taken = taken_mem[rd_ptr_q];

  always_comb begin
    state_d    = StRun;  // FLUSH always returns to RUN
    count_d    = count_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    redirect_d = redirect_q;
    hit_d      = hit_q;
    miss_d     = miss_q;
    err_d      = err_q;
    do_pop     = 1'b0;
    do_push    = 1'b0;
    mispredict = 1'b0;
    mem_we     = 1'b0;

    // In FLUSH both request inputs belong to the wrong path and are ignored.
    if (state_q == StRun) begin
      if (Resolve_Valid_IN) begin
        if (empty) begin
          mispredict = 1'b1;
          err_d      = 1'b1;
        end else begin
          do_pop = 1'b1;
          if (head_pc != Resolve_PC_IN) err_d = 1'b1;
          if (!(head_taken && head_addr == Resolve_Target_IN && head_pc == Resolve_PC_IN)) begin
            mispredict = 1'b1;
          end
        end
      end

      if (mispredict) begin
        // Everything queued is younger than the mispredicted JR, so drop it all,
        // including a same-cycle push.
        state_d    = StFlush;
        count_d    = '0;
        wr_ptr_d   = '0;
        rd_ptr_d   = '0;
        redirect_d = Resolve_Target_IN;
        if (miss_q != '1) miss_d = miss_q + CNT_W'(1);
      end else begin
        if (do_pop) begin
          rd_ptr_d = rd_ptr_q + PtrW'(1);
          if (hit_q != '1) hit_d = hit_q + CNT_W'(1);
        end
        // A same-cycle hit frees the head slot, so a push is legal even when full.
        if (Pred_Valid_IN) begin
          if (!full || do_pop) do_push = 1'b1;
          else                 err_d   = 1'b1;
        end
        if (do_push) begin
          mem_we   = 1'b1;
          wr_ptr_d = wr_ptr_q + PtrW'(1);
        end
        unique case ({do_push, do_pop})
          2'b10:   count_d = count_q + CntW'(1);
          2'b01:   count_d = count_q - CntW'(1);
          default: count_d = count_q;
        endcase
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q    <= StRun;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      redirect_q <= '0;
      hit_q      <= '0;
      miss_q     <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      redirect_q <= redirect_d;
      hit_q      <= hit_d;
      miss_q     <= miss_d;
      err_q      <= err_d;
    end
  end

  // Queue storage needs no reset: entries are only read while count_q says valid.
  always_ff @(posedge CLK) begin
    if (mem_we) begin
      pc_mem[wr_ptr_q]    <= Pred_PC_IN;
      addr_mem[wr_ptr_q]  <= Pred_Addr_IN;
      taken_mem[wr_ptr_q] <= Pred_Taken_IN;
    end
  end

  assign FLUSH_OUT         = (state_q == StFlush);
  assign Redirect_Addr_OUT = redirect_q;
  assign Full_OUT          = full;
  assign Hit_Count_OUT     = hit_q;
  assign Miss_Count_OUT    = miss_q;
  assign Error_OUT         = err_q;

endmodule

// File: tb/tb_jr_resolve_unit.sv
// Testbench for jr_resolve_unit: directed scenarios plus a randomized run checked
// against a queue-based reference model. Narrow counters make saturation reachable.
module tb_jr_resolve_unit;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned CNT_W = 4;
  localparam int          MAXC  = (1 << CNT_W) - 1;

  logic             CLK;
  logic             RESET;
  logic             Pred_Valid_IN, Pred_Taken_IN;
  logic [31:0]      Pred_Addr_IN, Pred_PC_IN;
  logic             Resolve_Valid_IN;
  logic [31:0]      Resolve_PC_IN, Resolve_Target_IN;
  logic             FLUSH_OUT;
  logic [31:0]      Redirect_Addr_OUT;
  logic             Full_OUT;
  logic [CNT_W-1:0] Hit_Count_OUT, Miss_Count_OUT;
  logic             Error_OUT;

  int n_checks = 0;
  int n_fail   = 0;

  jr_resolve_unit #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .CLK               (CLK),
    .RESET             (RESET),
    .Pred_Valid_IN     (Pred_Valid_IN),
    .Pred_Taken_IN     (Pred_Taken_IN),
    .Pred_Addr_IN      (Pred_Addr_IN),
    .Pred_PC_IN        (Pred_PC_IN),
    .Resolve_Valid_IN  (Resolve_Valid_IN),
    .Resolve_PC_IN     (Resolve_PC_IN),
    .Resolve_Target_IN (Resolve_Target_IN),
    .FLUSH_OUT         (FLUSH_OUT),
    .Redirect_Addr_OUT (Redirect_Addr_OUT),
    .Full_OUT          (Full_OUT),
    .Hit_Count_OUT     (Hit_Count_OUT),
    .Miss_Count_OUT    (Miss_Count_OUT),
    .Error_OUT         (Error_OUT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Reference model: a plain queue of outstanding predictions.
  typedef struct {
    logic [31:0] pc;
    logic [31:0] addr;
    logic        taken;
  } ent_t;

  ent_t        m_q[$];
  bit          m_flush;
  logic [31:0] m_redir;
  int          m_hit, m_miss;
  bit          m_err;

  task automatic model_reset();
    m_q.delete();
    m_flush = 0;
    m_redir = '0;
    m_hit   = 0;
    m_miss  = 0;
    m_err   = 0;
  endtask

  task automatic model_step(input logic pv, input logic pt, input logic [31:0] pa,
                            input logic [31:0] ppc, input logic rv,
                            input logic [31:0] rpc, input logic [31:0] rt);
    ent_t h;
    bit   miss;
    if (m_flush) begin
      m_flush = 0;
      return;
    end
    miss = 0;
    if (rv) begin
      if (m_q.size() == 0) begin
        m_err = 1;
        miss  = 1;
      end else begin
        h = m_q.pop_front();
        if (h.pc != rpc) m_err = 1;
        if (h.taken && h.addr == rt && h.pc == rpc) begin
          if (m_hit < MAXC) m_hit++;
        end else begin
          miss = 1;
        end
      end
    end
    if (miss) begin
      m_q.delete();
      m_redir = rt;
      m_flush = 1;
      if (m_miss < MAXC) m_miss++;
    end else if (pv) begin
      if (m_q.size() < DEPTH) m_q.push_back('{pc: ppc, addr: pa, taken: pt});
      else                    m_err = 1;
    end
  endtask

  // One clock cycle: apply inputs, advance model at the edge, sample 1ns later.
  task automatic cyc(input logic pv, input logic pt, input logic [31:0] pa,
                     input logic [31:0] ppc, input logic rv,
                     input logic [31:0] rpc, input logic [31:0] rt);
    Pred_Valid_IN     = pv;
    Pred_Taken_IN     = pt;
    Pred_Addr_IN      = pa;
    Pred_PC_IN        = ppc;
    Resolve_Valid_IN  = rv;
    Resolve_PC_IN     = rpc;
    Resolve_Target_IN = rt;
    @(posedge CLK);
    model_step(pv, pt, pa, ppc, rv, rpc, rt);
    #1;
    Pred_Valid_IN    = 1'b0;
    Resolve_Valid_IN = 1'b0;
  endtask

  task automatic apply_reset();
    #2 RESET = 1'b0;
    model_reset();
    #1;
    @(negedge CLK);
    RESET = 1'b1;
  endtask

  task automatic test_reset();
    RESET = 1'b0;
    Pred_Valid_IN = 0; Pred_Taken_IN = 0; Pred_Addr_IN = '0; Pred_PC_IN = '0;
    Resolve_Valid_IN = 0; Resolve_PC_IN = '0; Resolve_Target_IN = '0;
    model_reset();
    #3;
    n_checks++;
    if ({FLUSH_OUT, Full_OUT, Error_OUT} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_flags got flush/full/err=%b%b%b exp 000", FLUSH_OUT, Full_OUT, Error_OUT);
    end
    n_checks++;
    if (Hit_Count_OUT !== '0 || Miss_Count_OUT !== '0 || Redirect_Addr_OUT !== '0) begin
      n_fail++;
      $display("FAIL reset_regs got hit=%0d miss=%0d redir=%h exp 0 0 0",
               Hit_Count_OUT, Miss_Count_OUT, Redirect_Addr_OUT);
    end
    @(negedge CLK);
    RESET = 1'b1;
  endtask

  task automatic test_hit();
    cyc(1, 1, 32'h208, 32'h100, 0, '0, '0);
    cyc(0, 0, '0, '0, 1, 32'h100, 32'h208);
    n_checks++;
    if (Hit_Count_OUT !== CNT_W'(1) || FLUSH_OUT !== 1'b0) begin
      n_fail++;
      $display("FAIL hit got hit=%0d flush=%b exp 1 0", Hit_Count_OUT, FLUSH_OUT);
    end
    // Queue must be empty: a further resolve is an error and a flush.
    cyc(0, 0, '0, '0, 1, 32'h100, 32'h208);
    n_checks++;
    if (Error_OUT !== 1'b1 || FLUSH_OUT !== 1'b1 || Miss_Count_OUT !== CNT_W'(1)) begin
      n_fail++;
      $display("FAIL hit_empty_after got err=%b flush=%b miss=%0d exp 1 1 1",
               Error_OUT, FLUSH_OUT, Miss_Count_OUT);
    end
    cyc(0, 0, '0, '0, 0, '0, '0);
  endtask

  task automatic test_miss();
    apply_reset();
    cyc(1, 1, 32'h208, 32'h100, 0, '0, '0);
    cyc(0, 0, '0, '0, 1, 32'h100, 32'h30C);
    n_checks++;
    if (FLUSH_OUT !== 1'b1 || Redirect_Addr_OUT !== 32'h30C || Miss_Count_OUT !== CNT_W'(1)) begin
      n_fail++;
      $display("FAIL miss got flush=%b redir=%h miss=%0d exp 1 0000030c 1",
               FLUSH_OUT, Redirect_Addr_OUT, Miss_Count_OUT);
    end
    cyc(0, 0, '0, '0, 0, '0, '0);
    n_checks++;
    if (FLUSH_OUT !== 1'b0 || Redirect_Addr_OUT !== 32'h30C || Error_OUT !== 1'b0) begin
      n_fail++;
      $display("FAIL miss_after got flush=%b redir=%h err=%b exp 0 0000030c 0",
               FLUSH_OUT, Redirect_Addr_OUT, Error_OUT);
    end
  endtask

  task automatic test_not_taken();
    cyc(1, 0, 32'h0, 32'h40, 0, '0, '0);
    cyc(0, 0, '0, '0, 1, 32'h40, 32'h48);
    n_checks++;
    if (FLUSH_OUT !== 1'b1 || Redirect_Addr_OUT !== 32'h48 || Miss_Count_OUT !== CNT_W'(2)
        || Error_OUT !== 1'b0) begin
      n_fail++;
      $display("FAIL not_taken got flush=%b redir=%h miss=%0d err=%b exp 1 00000048 2 0",
               FLUSH_OUT, Redirect_Addr_OUT, Miss_Count_OUT, Error_OUT);
    end
    cyc(0, 0, '0, '0, 0, '0, '0);
  endtask

  task automatic test_full();
    apply_reset();
    for (int i = 0; i < DEPTH; i++) cyc(1, 1, 32'h1000 + i * 4, 32'h200 + i * 4, 0, '0, '0);
    n_checks++;
    if (Full_OUT !== 1'b1 || Error_OUT !== 1'b0) begin
      n_fail++;
      $display("FAIL full got full=%b err=%b exp 1 0", Full_OUT, Error_OUT);
    end
    // Push together with a hit while full: slot recycled, no error.
    cyc(1, 1, 32'h1010, 32'h210, 1, 32'h200, 32'h1000);
    n_checks++;
    if (Full_OUT !== 1'b1 || Error_OUT !== 1'b0 || Hit_Count_OUT !== CNT_W'(1)) begin
      n_fail++;
      $display("FAIL full_push_pop got full=%b err=%b hit=%0d exp 1 0 1",
               Full_OUT, Error_OUT, Hit_Count_OUT);
    end
    cyc(1, 1, 32'h1014, 32'h214, 0, '0, '0);
    n_checks++;
    if (Error_OUT !== 1'b1 || Full_OUT !== 1'b1) begin
      n_fail++;
      $display("FAIL full_drop got err=%b full=%b exp 1 1", Error_OUT, Full_OUT);
    end
    // Dropped push must not have overwritten the queue: next heads are 0x204, 0x208.
    cyc(0, 0, '0, '0, 1, 32'h204, 32'h1004);
    cyc(0, 0, '0, '0, 1, 32'h208, 32'h1008);
    n_checks++;
    if (Hit_Count_OUT !== CNT_W'(3) || FLUSH_OUT !== 1'b0 || Full_OUT !== 1'b0) begin
      n_fail++;
      $display("FAIL full_order got hit=%0d flush=%b full=%b exp 3 0 0",
               Hit_Count_OUT, FLUSH_OUT, Full_OUT);
    end
  endtask

  task automatic test_flush_clear();
    apply_reset();
    for (int i = 0; i < 3; i++) cyc(1, 1, 32'h500 + i * 4, 32'h80 + i * 4, 0, '0, '0);
    cyc(0, 0, '0, '0, 1, 32'h80, 32'h999);
    n_checks++;
    if (FLUSH_OUT !== 1'b1 || Redirect_Addr_OUT !== 32'h999 || Error_OUT !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_clear got flush=%b redir=%h err=%b exp 1 00000999 0",
               FLUSH_OUT, Redirect_Addr_OUT, Error_OUT);
    end
    // Push and resolve during FLUSH are both wrong-path.
    cyc(1, 1, 32'h600, 32'h90, 1, 32'h84, 32'h504);
    n_checks++;
    if (FLUSH_OUT !== 1'b0 || Hit_Count_OUT !== '0 || Miss_Count_OUT !== CNT_W'(1)
        || Error_OUT !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_ignore got flush=%b hit=%0d miss=%0d err=%b exp 0 0 1 0",
               FLUSH_OUT, Hit_Count_OUT, Miss_Count_OUT, Error_OUT);
    end
    cyc(0, 0, '0, '0, 1, 32'h90, 32'h600);
    n_checks++;
    if (Error_OUT !== 1'b1 || FLUSH_OUT !== 1'b1 || Redirect_Addr_OUT !== 32'h600
        || Miss_Count_OUT !== CNT_W'(2)) begin
      n_fail++;
      $display("FAIL flush_empty got err=%b flush=%b redir=%h miss=%0d exp 1 1 00000600 2",
               Error_OUT, FLUSH_OUT, Redirect_Addr_OUT, Miss_Count_OUT);
    end
  endtask

  task automatic test_reset_mid_flush();
    cyc(1, 1, 32'h700, 32'hA0, 0, '0, '0);
    cyc(0, 0, '0, '0, 1, 32'hA0, 32'h7FF);
    #2 RESET = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if ({FLUSH_OUT, Full_OUT, Error_OUT} !== 3'b000 || Hit_Count_OUT !== '0
        || Miss_Count_OUT !== '0 || Redirect_Addr_OUT !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_flush got flush=%b full=%b err=%b hit=%0d miss=%0d redir=%h exp all 0",
               FLUSH_OUT, Full_OUT, Error_OUT, Hit_Count_OUT, Miss_Count_OUT, Redirect_Addr_OUT);
    end
    @(negedge CLK);
    RESET = 1'b1;
    // Queue count must be 0 as well: a resolve right away finds it empty.
    cyc(0, 0, '0, '0, 1, 32'hA0, 32'h700);
    n_checks++;
    if (Error_OUT !== 1'b1 || FLUSH_OUT !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid_flush_empty got err=%b flush=%b exp 1 1", Error_OUT, FLUSH_OUT);
    end
  endtask

  task automatic test_random();
    logic        pv, pt, rv;
    logic [31:0] pa, ppc, rpc, rt;
    for (int i = 0; i < 2000; i++) begin
      if (i % 250 == 0) apply_reset();
      pv  = ($urandom_range(0, 99) < 45);
      pt  = ($urandom_range(0, 99) < 85);
      pa  = {20'h0, $urandom_range(0, 255) * 4};
      ppc = {20'h1, $urandom_range(0, 255) * 4};
      rv  = ($urandom_range(0, 99) < 40);
      if (m_q.size() != 0 && $urandom_range(0, 99) < 80) begin
        rpc = m_q[0].pc;
        rt  = m_q[0].addr;
        if ($urandom_range(0, 99) < 10) rpc = rpc ^ 32'h4;
      end else begin
        rpc = {20'h1, $urandom_range(0, 255) * 4};
        rt  = {20'h0, $urandom_range(0, 255) * 4};
      end
      cyc(pv, pt, pa, ppc, rv, rpc, rt);
      n_checks++;
      if (FLUSH_OUT !== m_flush) begin
        n_fail++;
        $display("FAIL rnd_flush cyc %0d got %b exp %b", i, FLUSH_OUT, m_flush);
      end
      n_checks++;
      if (Redirect_Addr_OUT !== m_redir) begin
        n_fail++;
        $display("FAIL rnd_redirect cyc %0d got %h exp %h", i, Redirect_Addr_OUT, m_redir);
      end
      n_checks++;
      if (Full_OUT !== (m_q.size() == DEPTH)) begin
        n_fail++;
        $display("FAIL rnd_full cyc %0d got %b exp %b", i, Full_OUT, m_q.size() == DEPTH);
      end
      n_checks++;
      if (Hit_Count_OUT !== CNT_W'(m_hit) || Miss_Count_OUT !== CNT_W'(m_miss)) begin
        n_fail++;
        $display("FAIL rnd_counts cyc %0d got hit=%0d miss=%0d exp %0d %0d",
                 i, Hit_Count_OUT, Miss_Count_OUT, m_hit, m_miss);
      end
      n_checks++;
      if (Error_OUT !== m_err) begin
        n_fail++;
        $display("FAIL rnd_error cyc %0d got %b exp %b", i, Error_OUT, m_err);
      end
    end
  endtask

  initial begin
    test_reset();
    test_hit();
    test_miss();
    test_not_taken();
    test_full();
    test_flush_clear();
    test_reset_mid_flush();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/jr_resolve_unit.md
# jr_resolve_unit

Execute-stage checker for return-address predictions: records each JR prediction issued at fetch in a small in-order queue, compares it with the real register target when the JR resolves, and raises a one-cycle FLUSH plus redirect address on mispredict. It is the consumer end of the return-address predictor's Valid/Addr outputs. Its FLUSH_OUT drives the predictor's and the pipeline's FLUSH inputs.

## Interface
- DEPTH, 4, prediction queue entries (power of two, 2..16)
- CNT_W, 16, width of hit/miss statistic counters
- CLK  in  1  clock, all state updates on rising edge
- RESET  in  1  asynchronous, active-low reset
- Pred_Valid_IN  in  1  fetch issued a JR this cycle (enqueue request)
- Pred_Taken_IN  in  1  predictor supplied a target (its Valid_OUT)
- Pred_Addr_IN  in  32  predicted target (its Addr_OUT)
- Pred_PC_IN  in  32  address of the fetched JR
- Resolve_Valid_IN  in  1  a JR resolves in execute this cycle
- Resolve_PC_IN  in  32  address of the resolving JR
- Resolve_Target_IN  in  32  actual jump target (rs value)
- FLUSH_OUT  out  1  one-cycle pipeline flush on mispredict
- Redirect_Addr_OUT  out  32  correct fetch address, meaningful only while FLUSH_OUT=1
- Full_OUT  out  1  queue holds DEPTH entries; fetch must stall JRs
- Hit_Count_OUT  out  CNT_W  correct predictions, saturating
- Miss_Count_OUT  out  CNT_W  mispredictions, saturating
- Error_OUT  out  1  sticky protocol error

## Operation
- Queue entry: {pc[31:0], addr[31:0], taken}. FIFO, head = oldest; count register 0..DEPTH; read/write pointers wrap mod DEPTH.
- FSM states: RUN, FLUSH.
- RUN, Resolve_Valid_IN=1, queue non-empty: pop head. Hit iff head.taken=1 and head.addr==Resolve_Target_IN and head.pc==Resolve_PC_IN. Hit -> Hit_Count+1. Otherwise -> Miss_Count+1, clear queue (count=0, pointers reset), Redirect_Addr_OUT<=Resolve_Target_IN, go FLUSH.
- head.pc != Resolve_PC_IN additionally sets Error_OUT.
- Resolve with empty queue: Error_OUT=1, treated as miss (flush+redirect to Resolve_Target_IN), Miss_Count+1.
- RUN, Pred_Valid_IN=1: enqueue at tail unless full. Push while full: dropped, Error_OUT=1.
- Simultaneous push and hit-resolve: both occur, count unchanged; legal when full (pop frees the slot in the same cycle).
- Simultaneous push and miss-resolve: push discarded (wrong path).
- FLUSH: FLUSH_OUT=1 for exactly one cycle; Pred_Valid_IN and Resolve_Valid_IN ignored (wrong-path); next state RUN unconditionally.
- Counters saturate at 2^CNT_W-1; no wrap.
- Error_OUT clears only on reset.
- Full_OUT = (count==DEPTH), combinational from registered count.

## Timing
- Reset (RESET=0, asynchronous): state RUN, count=0, pointers=0, FLUSH_OUT=0, Redirect_Addr_OUT=0, Hit/Miss counts=0, Error_OUT=0. Reset mid-FLUSH aborts the flush immediately.
- Enqueue at edge ending cycle N; entry resolvable from cycle N+1. Same-cycle enqueue and resolve of the same JR is not supported; the resolve sees the prior head.
- Mispredict resolved in cycle N -> FLUSH_OUT=1 and Redirect_Addr_OUT valid in cycle N+1, low in N+2. Queue empty from N+1.
- Counters update at the edge ending the resolve cycle; visible in N+1.
- Redirect_Addr_OUT holds its value after FLUSH until the next miss.
- Full_OUT reflects count at cycle start; it does not drop combinationally on a same-cycle pop.

## Test plan
- Reset, push PC=0x100 taken addr=0x208, resolve PC=0x100 target=0x208 -> Hit_Count=1, FLUSH_OUT stays 0, queue empty.
- Push PC=0x100 taken addr=0x208, resolve target=0x30C -> next cycle FLUSH_OUT=1, Redirect_Addr_OUT=0x30C, Miss_Count=1; FLUSH_OUT=0 the cycle after.
- Push PC=0x40 with Pred_Taken_IN=0 (predictor empty), resolve target=0x48 -> counted as miss, flush to 0x48.
- DEPTH=4: push 4 entries -> Full_OUT=1; 5th push dropped, Error_OUT=1; push+hit-resolve in the same cycle while full -> count stays 4, no error added.
- Push 3, miss on the first -> queue cleared; a push during the FLUSH cycle is ignored; the next resolve finds the queue empty -> Error_OUT=1 and flush.
- Assert RESET low during FLUSH_OUT=1 -> FLUSH_OUT, counts, Error_OUT and count all 0 immediately, without waiting for a clock edge.
